// File: rtl/mips_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter_pkg
//   Shared types and constants for the two-master Avalon-style bus arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   - DATA_WIDTH  : data bus width (fixed at 32)
//   - BE_WIDTH    : byteenable width (fixed at 4)
//   - grant_state : maps a grant index to its GRANT state
// ---------------------------------------------------------------------------
package mips_bus_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_select.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter_select
//   Combinational winner selection between two requesting masters.
//   Configuration macro: ARBITER_ROUND_ROBIN_EN
//     defined   : on a tie the master other than last_grant wins
//     undefined : fixed priority, master 0 wins every tie (last_grant ignored)
//   Ports:
//     req0, req1   in  : request from master 0 / master 1
//     last_grant   in  : index of the most recently granted master
//     grant_idx    out : winning master index (meaningful when grant_valid)
//     grant_valid  out : at least one master is requesting
// ---------------------------------------------------------------------------
module mips_bus_arbiter_select (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_idx,
  output logic grant_valid
);

  logic tie_winner;

`ifdef ARBITER_ROUND_ROBIN_EN
  // Alternate on contention: whoever was not served last goes first.
  assign tie_winner = ~last_grant;
`else
  // Fixed priority: master 0 always wins; history is irrelevant here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign tie_winner        = 1'b0;
`endif

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = tie_winner;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter
//   Shares one Avalon-style memory slave port between two masters. A grant
//   is held for exactly one transfer (or until the request is withdrawn),
//   after which the FSM returns to IDLE for one cycle and re-arbitrates.
//   Configuration macro: ARBITER_ROUND_ROBIN_EN (tie policy, see
//   mips_bus_arbiter_select).
//   Ports:
//     clk, reset                  : clock, synchronous active-high reset
//     mX_address/read/write/
//       byteenable/writedata  in  : master X request signals
//     mX_readdata             out : slave read data (valid on completion)
//     mX_waitrequest          out : stall to master X
//     s_address/read/write/
//       byteenable/writedata  out : muxed request towards memory
//     s_readdata, s_waitrequest in: memory response
// ---------------------------------------------------------------------------
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,

  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,

  output logic [ADDR_WIDTH-1:0] s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_waitrequest
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;

  logic req0, req1;
  logic grant_idx, grant_valid;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  mips_bus_arbiter_select u_select (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Next-state logic. A GRANT state is left either on completion
  // (req & !s_waitrequest) or when the master withdraws its request, so the
  // only way to stay is "still requesting and still stalled".
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = grant_state(grant_idx);
          last_grant_d = grant_idx;
        end
      end
      GRANT0: begin
        if (!(req0 && s_waitrequest)) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        if (!(req1 && s_waitrequest)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so that master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave-side mux: driven straight from the granted master, all zeros in
  // IDLE. Kept combinational so an aborting master's read/write drop is
  // visible to the memory in the same cycle.
  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_byteenable = '0;
    s_writedata  = '0;
    unique case (state_q)
      GRANT0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_write      = m0_write;
        s_byteenable = m0_byteenable;
        s_writedata  = m0_writedata;
      end
      GRANT1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
      end
      default: begin
      end
    endcase
  end

  // A master is released only while it holds the grant and the slave is
  // ready; everyone else is stalled.
  assign m0_waitrequest = !((state_q == GRANT0) && !s_waitrequest);
  assign m1_waitrequest = !((state_q == GRANT1) && !s_waitrequest);

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_bus_arbiter
//   Directed-vector bench for mips_bus_arbiter. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled 2 units later. The slave
//   (s_readdata / s_waitrequest) is driven directly by the bench.
//   Tie expectations follow ARBITER_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_waitrequest;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_byteenable  (m0_byteenable),
    .m0_writedata   (m0_writedata),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_byteenable  (m1_byteenable),
    .m1_writedata   (m1_writedata),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_byteenable   (s_byteenable),
    .s_writedata    (s_writedata),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest)
  );

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (mid-cycle).
  task automatic settle();
    #2;
  endtask

  task automatic clear_masters();
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0;
    m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
    m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_masters();
    s_readdata = '0;
    s_waitrequest = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    settle();
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL reset_s_read got %0h exp 0", s_read); end
    vectors++; if (s_write !== 1'b0) begin miscompares++; $display("FAIL reset_s_write got %0h exp 0", s_write); end
    vectors++; if (s_address !== 32'h0) begin miscompares++; $display("FAIL reset_s_address got %h exp 00000000", s_address); end
    vectors++; if (s_byteenable !== 4'h0) begin miscompares++; $display("FAIL reset_s_byteenable got %h exp 0", s_byteenable); end
    vectors++; if (s_writedata !== 32'h0) begin miscompares++; $display("FAIL reset_s_writedata got %h exp 00000000", s_writedata); end
    vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_m0_wait got %0h exp 1", m0_waitrequest); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_single_read();
    // cycle 0: request seen in IDLE
    m0_address = 32'hBFC00000; m0_read = 1'b1; m0_byteenable = 4'hF;
    s_waitrequest = 1'b0; s_readdata = 32'h24020005;
    settle();
    vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL single_c0_m0_wait got %0h exp 1", m0_waitrequest); end
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL single_c0_s_read got %0h exp 0", s_read); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL single_c0_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    // cycle 1: GRANT0, completion
    settle();
    vectors++; if (s_read !== 1'b1) begin miscompares++; $display("FAIL single_c1_s_read got %0h exp 1", s_read); end
    vectors++; if (s_address !== 32'hBFC00000) begin miscompares++; $display("FAIL single_c1_s_address got %h exp bfc00000", s_address); end
    vectors++; if (m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL single_c1_m0_wait got %0h exp 0", m0_waitrequest); end
    vectors++; if (m0_readdata !== 32'h24020005) begin miscompares++; $display("FAIL single_c1_m0_readdata got %h exp 24020005", m0_readdata); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL single_c1_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    clear_masters();
    // cycle 2: back in IDLE
    settle();
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL single_c2_s_read got %0h exp 0", s_read); end
    vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL single_c2_m0_wait got %0h exp 1", m0_waitrequest); end
    $display("test_single_read: m0 read bfc00000 -> 24020005");
    tick();
  endtask

  task automatic test_tie();
    logic exp_m1_second_tie;
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_m1_second_tie = 1'b1;
`else
    exp_m1_second_tie = 1'b0;
`endif
    clear_masters();
    do_reset();
    s_waitrequest = 1'b0; s_readdata = 32'h11112222;
    // cycle 0: first tie
    m0_address = 32'h00000100; m0_read = 1'b1; m0_byteenable = 4'hF;
    m1_address = 32'h00000200; m1_read = 1'b1; m1_byteenable = 4'hF;
    settle();
    vectors++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_c0_waits got %0h%0h exp 11", m0_waitrequest, m1_waitrequest); end
    tick();
    // cycle 1: m0 wins first tie in both modes
    settle();
    vectors++; if (s_address !== 32'h00000100) begin miscompares++; $display("FAIL tie_c1_s_address got %h exp 00000100", s_address); end
    vectors++; if (m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_c1_m0_wait got %0h exp 0", m0_waitrequest); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_c1_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    // cycle 2: m0 immediately issues a new read -> second tie in IDLE
    m0_address = 32'h00000300;
    settle();
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL tie_c2_s_read got %0h exp 0", s_read); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_c2_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    // cycle 3: winner of the second tie
    settle();
    if (exp_m1_second_tie) begin
      vectors++; if (s_address !== 32'h00000200) begin miscompares++; $display("FAIL tie_c3_s_address got %h exp 00000200", s_address); end
      vectors++; if (m1_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_c3_m1_wait got %0h exp 0", m1_waitrequest); end
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_c3_m0_wait got %0h exp 1", m0_waitrequest); end
      tick();
      m1_read = 1'b0;
    end else begin
      vectors++; if (s_address !== 32'h00000300) begin miscompares++; $display("FAIL tie_c3_s_address got %h exp 00000300", s_address); end
      vectors++; if (m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_c3_m0_wait got %0h exp 0", m0_waitrequest); end
      vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL tie_c3_m1_wait got %0h exp 1", m1_waitrequest); end
      tick();
      m0_read = 1'b0;
    end
    // cycle 4: IDLE bubble; cycle 5: the loser of the second tie is served
    settle();
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL tie_c4_s_read got %0h exp 0", s_read); end
    tick();
    settle();
    if (exp_m1_second_tie) begin
      vectors++; if (s_address !== 32'h00000300 || m0_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_c5_m0_served got addr %h wait %0h exp 00000300 0", s_address, m0_waitrequest); end
    end else begin
      vectors++; if (s_address !== 32'h00000200 || m1_waitrequest !== 1'b0) begin miscompares++; $display("FAIL tie_c5_m1_served got addr %h wait %0h exp 00000200 0", s_address, m1_waitrequest); end
    end
    tick();
    clear_masters();
    tick();
    $display("test_tie: second tie winner expected m%0d", exp_m1_second_tie);
  endtask

  task automatic test_waitstate_write();
    int releases = 0;
    clear_masters();
    s_waitrequest = 1'b1;
    // cycle 0: m1 write request in IDLE
    m1_address = 32'h00000010; m1_write = 1'b1;
    m1_byteenable = 4'b0011; m1_writedata = 32'hDEADBEEF;
    settle();
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL ws_c0_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    // m0 starts requesting while m1 owns the bus
    m0_address = 32'h00000040; m0_read = 1'b1; m0_byteenable = 4'hF;
    for (int c = 1; c <= 4; c++) begin
      s_waitrequest = (c <= 3);
      settle();
      vectors++; if (s_write !== 1'b1 || s_read !== 1'b0) begin miscompares++; $display("FAIL ws_c%0d_s_rw got %0h%0h exp 10", c, s_write, s_read); end
      vectors++; if (s_address !== 32'h10 || s_byteenable !== 4'b0011 || s_writedata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ws_c%0d_s_bus got %h %h %h exp 00000010 3 deadbeef", c, s_address, s_byteenable, s_writedata); end
      vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL ws_c%0d_m0_wait got %0h exp 1", c, m0_waitrequest); end
      if (m1_waitrequest === 1'b0) releases++;
      tick();
    end
    m1_write = 1'b0;
    s_waitrequest = 1'b0;
    // cycle 5: IDLE bubble, m0 still stalled
    settle();
    if (m1_waitrequest === 1'b0) releases++;
    vectors++; if (m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL ws_c5_m0_wait got %0h exp 1", m0_waitrequest); end
    vectors++; if (releases != 1) begin miscompares++; $display("FAIL ws_m1_release_count got %0d exp 1", releases); end
    tick();
    // cycle 6: m0 finally granted
    settle();
    vectors++; if (m0_waitrequest !== 1'b0 || s_address !== 32'h40) begin miscompares++; $display("FAIL ws_c6_m0_grant got wait %0h addr %h exp 0 00000040", m0_waitrequest, s_address); end
    tick();
    clear_masters();
    tick();
    $display("test_waitstate_write: m1 write deadbeef be=3 @00000010, 3 waitstates");
  endtask

  task automatic test_reset_mid_transfer();
    clear_masters();
    s_waitrequest = 1'b1;
    m0_address = 32'h00000080; m0_read = 1'b1; m0_byteenable = 4'hF;
    tick();
    // cycle 1: GRANT0 stalled by slave; assert reset for the coming edge
    settle();
    vectors++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_c1_grant got s_read %0h wait %0h exp 1 1", s_read, m0_waitrequest); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // cycle 2: IDLE after reset
    settle();
    vectors++; if (s_read !== 1'b0) begin miscompares++; $display("FAIL rst_c2_s_read got %0h exp 0", s_read); end
    vectors++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_c2_waits got %0h%0h exp 11", m0_waitrequest, m1_waitrequest); end
    tick();
    // cycle 3: held request re-granted and completes
    s_waitrequest = 1'b0;
    settle();
    vectors++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b0 || s_address !== 32'h80) begin miscompares++; $display("FAIL rst_c3_complete got rd %0h wait %0h addr %h exp 1 0 00000080", s_read, m0_waitrequest, s_address); end
    tick();
    clear_masters();
    tick();
    $display("test_reset_mid_transfer: m0 read @00000080 reissued");
  endtask

  task automatic test_abort();
    clear_masters();
    s_waitrequest = 1'b1;
    m0_address = 32'h00000090; m0_read = 1'b1; m0_byteenable = 4'hF;
    tick();
    // cycle 1: GRANT0, stalled; m1 write becomes pending
    m1_address = 32'h000000A0; m1_write = 1'b1; m1_byteenable = 4'hF; m1_writedata = 32'hCAFEF00D;
    settle();
    vectors++; if (s_read !== 1'b1 || m0_waitrequest !== 1'b1) begin miscompares++; $display("FAIL abort_c1_grant got rd %0h wait %0h exp 1 1", s_read, m0_waitrequest); end
    tick();
    // cycle 2: m0 withdraws; s_read follows immediately
    m0_read = 1'b0;
    settle();
    vectors++; if (s_read !== 1'b0 || s_write !== 1'b0) begin miscompares++; $display("FAIL abort_c2_s_rw got %0h%0h exp 00", s_read, s_write); end
    vectors++; if (m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL abort_c2_m1_wait got %0h exp 1", m1_waitrequest); end
    tick();
    // cycle 3: IDLE
    settle();
    vectors++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin miscompares++; $display("FAIL abort_c3_idle got wr %0h wait %0h exp 0 1", s_write, m1_waitrequest); end
    tick();
    // cycle 4: GRANT1
    s_waitrequest = 1'b0;
    settle();
    vectors++; if (s_write !== 1'b1 || s_address !== 32'hA0 || s_writedata !== 32'hCAFEF00D || m1_waitrequest !== 1'b0) begin miscompares++; $display("FAIL abort_c4_m1_grant got wr %0h addr %h wd %h wait %0h exp 1 000000a0 cafef00d 0", s_write, s_address, s_writedata, m1_waitrequest); end
    tick();
    clear_masters();
    tick();
    $display("test_abort: m0 aborted, m1 write @000000a0 granted");
  endtask

  initial begin
    reset = 1'b1;
    clear_masters();
    s_readdata = '0;
    s_waitrequest = 1'b0;
    test_reset();
    test_single_read();
    test_tie();
    test_waitstate_write();
    test_reset_mid_transfer();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
